time_set_controller: RTL and testbench



---
 rtl/time_set_controller.sv | 255 +++++++++++++++++++++++++
 tb/tb_time_set_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// -----------------------------------------------------------------------------
// time_set_controller
//
// Time-entry front end for the alarm-clock system counter. On a mode press it
// captures the counter's BCD time as binary hours/minutes. The user then edits
// the hours, then the minutes, with the up/down buttons. A final mode press
// commits the edited time by holding `load` long enough for the slow counter
// clock to sample it. An edit left idle too long is abandoned without a load.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-low reset
//   btn_mode       debounced single-cycle pulse, advances the edit sequence
//   btn_up         debounced single-cycle pulse, increments the selected field
//   btn_down       debounced single-cycle pulse, decrements the selected field
//   cur_min_units  BCD minute units read back from the counter
//   cur_min_tens   BCD minute tens read back from the counter
//   cur_hour_units BCD hour units read back from the counter
//   cur_hour_tens  BCD hour tens read back from the counter
//   time_minutes   binary minutes 0..59 to the counter load input
//   time_hours     binary hours 0..23 to the counter load input
//   load           counter parallel-load request
//   enable         counter run enable
//   edit_field     0 = none, 1 = hours, 2 = minutes, 3 = committing
//   blink          display blink gate for the selected field
//
// States
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_RUN      | counter running, buttons other than mode ignored
//   ST_SET_HOUR | counter stopped, up/down step the hours field
//   ST_SET_MIN  | counter stopped, up/down step the minutes field
//   ST_COMMIT   | load held high for LOAD_HOLD_CYCLES, all buttons ignored
// -----------------------------------------------------------------------------
module time_set_controller #(
  parameter int BLINK_CYCLES     = 25000000,
  parameter int TIMEOUT_CYCLES   = 1000000000,
  parameter int LOAD_HOLD_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] cur_min_units,
  input  logic [2:0] cur_min_tens,
  input  logic [3:0] cur_hour_units,
  input  logic [2:0] cur_hour_tens,
  output logic [5:0] time_minutes,
  output logic [4:0] time_hours,
  output logic       load,
  output logic       enable,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam int BLINK_W   = (BLINK_CYCLES > 1)     ? $clog2(BLINK_CYCLES)     : 1;
  localparam int TIMEOUT_W = (TIMEOUT_CYCLES > 1)   ? $clog2(TIMEOUT_CYCLES)   : 1;
  localparam int HOLD_W    = (LOAD_HOLD_CYCLES > 1) ? $clog2(LOAD_HOLD_CYCLES) : 1;

  // All timers are down-counters reloaded with (period - 1); reaching zero
  // marks the last cycle of the period.
  localparam logic [BLINK_W-1:0]   BLINK_RELOAD   = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_RELOAD = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0]    HOLD_RELOAD    = HOLD_W'(LOAD_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [4:0]           hours_q, hours_d;
  logic [5:0]           minutes_q, minutes_d;
  logic                 load_q, load_d;
  logic                 enable_q, enable_d;
  logic [1:0]           edit_field_q, edit_field_d;
  logic                 blink_q, blink_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic [TIMEOUT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;

  // ---------------------------------------------------------------------------
  // Capture: BCD read-back to binary. Any illegal digit or out-of-range value
  // zeroes only the offending field.
  // ---------------------------------------------------------------------------
  logic [6:0] hour_bin, min_bin;
  logic       hour_ok, min_ok;
  logic [4:0] cap_hours;
  logic [5:0] cap_minutes;

  assign hour_bin    = 7'(cur_hour_tens) * 7'd10 + 7'(cur_hour_units);
  assign min_bin     = 7'(cur_min_tens)  * 7'd10 + 7'(cur_min_units);
  assign hour_ok     = (cur_hour_units <= 4'd9) && (hour_bin <= 7'd23);
  assign min_ok      = (cur_min_units  <= 4'd9) && (min_bin  <= 7'd59);
  assign cap_hours   = hour_ok ? hour_bin[4:0] : 5'd0;
  assign cap_minutes = min_ok  ? min_bin[5:0]  : 6'd0;

  // ---------------------------------------------------------------------------
  // Button decode. Mode wins over up/down; up and down together cancel.
  // ---------------------------------------------------------------------------
  logic any_btn, step_up, step_dn;
  logic idle_done, hold_done;

  assign any_btn   = btn_mode | btn_up | btn_down;
  assign step_up   = btn_up   & ~btn_down & ~btn_mode;
  assign step_dn   = btn_down & ~btn_up   & ~btn_mode;
  assign idle_done = (idle_cnt_q == '0);
  assign hold_done = (hold_cnt_q == '0);

  // ---------------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      hours_q      <= '0;
      minutes_q    <= '0;
      load_q       <= 1'b0;
      enable_q     <= 1'b1;
      edit_field_q <= 2'd0;
      blink_q      <= 1'b0;
      blink_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      hours_q      <= hours_d;
      minutes_q    <= minutes_d;
      load_q       <= load_d;
      enable_q     <= enable_d;
      edit_field_q <= edit_field_d;
      blink_q      <= blink_d;
      blink_cnt_q  <= blink_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (btn_mode) state_d = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        if (btn_mode)                  state_d = ST_SET_MIN;
        else if (!any_btn && idle_done) state_d = ST_RUN;
      end
      ST_SET_MIN: begin
        if (btn_mode)                  state_d = ST_COMMIT;
        else if (!any_btn && idle_done) state_d = ST_RUN;
      end
      ST_COMMIT: begin
        if (hold_done) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values. Outputs are decoded from the next state so
  // that they change on the same edge as the state register.
  // ---------------------------------------------------------------------------
  logic edit_next, entering_edit, entering_commit;

  assign edit_next       = (state_d == ST_SET_HOUR) || (state_d == ST_SET_MIN);
  assign entering_edit   = edit_next && (state_d != state_q);
  assign entering_commit = (state_d == ST_COMMIT) && (state_q != ST_COMMIT);

  always_comb begin
    hours_d      = hours_q;
    minutes_d    = minutes_q;
    load_d       = 1'b0;
    enable_d     = 1'b0;
    edit_field_d = 2'd0;
    blink_d      = 1'b0;
    blink_cnt_d  = '0;
    idle_cnt_d   = TIMEOUT_RELOAD;
    hold_cnt_d   = '0;

    // Field updates; fields are frozen in COMMIT and after a timeout.
    case (state_q)
      ST_RUN: begin
        if (btn_mode) begin
          hours_d   = cap_hours;
          minutes_d = cap_minutes;
        end
      end
      ST_SET_HOUR: begin
        if (step_up)      hours_d = (hours_q == 5'd23) ? 5'd0  : hours_q + 5'd1;
        else if (step_dn) hours_d = (hours_q == 5'd0)  ? 5'd23 : hours_q - 5'd1;
      end
      ST_SET_MIN: begin
        if (step_up)      minutes_d = (minutes_q == 6'd59) ? 6'd0  : minutes_q + 6'd1;
        else if (step_dn) minutes_d = (minutes_q == 6'd0)  ? 6'd59 : minutes_q - 6'd1;
      end
      default: ;
    endcase

    // Blink restarts high on every entry into an edit field.
    if (entering_edit) begin
      blink_d     = 1'b1;
      blink_cnt_d = BLINK_RELOAD;
    end else if (edit_next) begin
      if (blink_cnt_q == '0) begin
        blink_d     = ~blink_q;
        blink_cnt_d = BLINK_RELOAD;
      end else begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q - 1'b1;
      end
    end

    // Idle timer counts only while staying in an edit state with no press;
    // a staying-without-press cycle implies the counter is still nonzero.
    if (edit_next && !entering_edit && !any_btn) begin
      idle_cnt_d = idle_cnt_q - 1'b1;
    end

    if (entering_commit) begin
      hold_cnt_d = HOLD_RELOAD;
    end else if (state_d == ST_COMMIT) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
    end

    case (state_d)
      ST_RUN: begin
        enable_d     = 1'b1;
        edit_field_d = 2'd0;
      end
      ST_SET_HOUR: edit_field_d = 2'd1;
      ST_SET_MIN:  edit_field_d = 2'd2;
      ST_COMMIT: begin
        load_d       = 1'b1;
        edit_field_d = 2'd3;
      end
      default: ;
    endcase
  end

  assign time_hours   = hours_q;
  assign time_minutes = minutes_q;
  assign load         = load_q;
  assign enable       = enable_q;
  assign edit_field   = edit_field_q;
  assign blink        = blink_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller with short timer parameters. A directed
// sequence walks the documented scenarios, then randomized button traffic
// follows. Every cycle the reference model's expected outputs are queued and
// a separate monitor compares them against the DUT on the falling edge.
module tb_time_set_controller;

  localparam int BLINK = 3;
  localparam int TMO   = 16;
  localparam int HOLD  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_up, btn_down;
  logic [3:0] cur_min_units, cur_hour_units;
  logic [2:0] cur_min_tens, cur_hour_tens;
  logic [5:0] time_minutes;
  logic [4:0] time_hours;
  logic       load, enable, blink;
  logic [1:0] edit_field;

  always #5 clk = ~clk;

  time_set_controller #(
    .BLINK_CYCLES    (BLINK),
    .TIMEOUT_CYCLES  (TMO),
    .LOAD_HOLD_CYCLES(HOLD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_mode      (btn_mode),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .cur_min_units (cur_min_units),
    .cur_min_tens  (cur_min_tens),
    .cur_hour_units(cur_hour_units),
    .cur_hour_tens (cur_hour_tens),
    .time_minutes  (time_minutes),
    .time_hours    (time_hours),
    .load          (load),
    .enable        (enable),
    .edit_field    (edit_field),
    .blink         (blink)
  );

  typedef struct {
    int hours;
    int minutes;
    int ld;
    int en;
    int field;
    int bl;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0=run 1=hours 2=minutes 3=committing, timing
  // expressed as elapsed cycles since entry / last activity.
  int md = 0, mh = 0, mm = 0;
  int cyc = 0, t_entry = 0, t_act = 0;

  function automatic int cap(int tens, int units, int maxv);
    int v;
    v = tens * 10 + units;
    if (units > 9 || v > maxv) return 0;
    return v;
  endfunction

  task automatic model_step(bit m, bit u, bit d, bit r);
    exp_t x;
    cyc++;
    if (!r) begin
      md = 0; mh = 0; mm = 0;
    end else begin
      case (md)
        0: if (m) begin
          mh = cap(int'(cur_hour_tens), int'(cur_hour_units), 23);
          mm = cap(int'(cur_min_tens), int'(cur_min_units), 59);
          md = 1; t_entry = cyc; t_act = cyc;
        end
        1, 2: begin
          if (m) begin
            md = md + 1; t_entry = cyc; t_act = cyc;
          end else if (u || d) begin
            t_act = cyc;
            if (u && !d) begin
              if (md == 1) mh = (mh + 1) % 24; else mm = (mm + 1) % 60;
            end else if (d && !u) begin
              if (md == 1) mh = (mh + 23) % 24; else mm = (mm + 59) % 60;
            end
          end else if (cyc - t_act == TMO) begin
            md = 0;
          end
        end
        default: if (cyc - t_entry == HOLD) md = 0;
      endcase
    end
    x.hours   = mh;
    x.minutes = mm;
    x.ld      = (md == 3) ? 1 : 0;
    x.en      = (md == 0) ? 1 : 0;
    x.field   = md;
    x.bl      = (md == 1 || md == 2) ? ((((cyc - t_entry) / BLINK) % 2 == 0) ? 1 : 0) : 0;
    x.cyc     = cyc;
    sb.push_back(x);
  endtask

  task automatic tick(bit m, bit u, bit d, bit r);
    btn_mode = m; btn_up = u; btn_down = d; reset = r;
    @(posedge clk);
    model_step(m, u, d, r);
    #1;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; reset = 1'b1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic set_digits(int ht, int hu, int mt, int mu);
    cur_hour_tens  = 3'(ht);
    cur_hour_units = 4'(hu);
    cur_min_tens   = 3'(mt);
    cur_min_units  = 4'(mu);
  endtask

  task automatic chk(string nm, int act, int exp, int c);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, c, act, exp);
    end
  endtask

  // Monitor: registered outputs are stable by the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("time_hours",   int'(time_hours),   e.hours,   e.cyc);
        chk("time_minutes", int'(time_minutes), e.minutes, e.cyc);
        chk("load",         int'(load),         e.ld,      e.cyc);
        chk("enable",       int'(enable),       e.en,      e.cyc);
        chk("edit_field",   int'(edit_field),   e.field,   e.cyc);
        chk("blink",        int'(blink),        e.bl,      e.cyc);
      end
    end
  end

  initial begin
    reset = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    set_digits(0, 0, 0, 0);
    #2;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Capture 17:42, then hours wrap both ways.
    set_digits(1, 7, 4, 2);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b1);

    // Mode with up: hours unchanged, advance to minutes.
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);

    // Idle in minutes until the edit times out.
    idle(20);

    // Edit to 08:30 and commit; buttons during commit are ignored.
    set_digits(0, 9, 3, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    idle(8);

    // Invalid capture, then reset during commit.
    set_digits(2, 9, 7, 1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic with occasional quiet stretches.
    for (int blk = 0; blk < 120; blk++) begin
      bit quiet;
      quiet = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) != 0)
        set_digits($urandom_range(0, 2), $urandom_range(0, 9),
                   $urandom_range(0, 5), $urandom_range(0, 9));
      else
        set_digits($urandom_range(0, 7), $urandom_range(0, 15),
                   $urandom_range(0, 7), $urandom_range(0, 15));
      for (int i = 0; i < 30; i++) begin
        if (quiet) tick(1'b0, 1'b0, 1'b0, 1'b1);
        else tick($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 299) != 0);
      end
    end

    idle(2);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
